// File: rtl/ghash_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ghash_ctrl_if
// Purpose  : Block-in / tag-out handshake bundle for the GHASH controller.
// Revision : 1.0  initial release
// ============================================================================
interface ghash_ctrl_if #(
    parameter int W = 128
) ();
    logic         blk_valid;
    logic         blk_ready;
    logic [W-1:0] blk_data;
    logic         blk_last;
    logic         blk_aad;
    logic         tag_valid;
    logic         tag_ready;
    logic [W-1:0] tag;

    // master: message source and tag consumer; slave: the controller
    modport master (
        output blk_valid, blk_data, blk_last, blk_aad, tag_ready,
        input  blk_ready, tag_valid, tag
    );

    modport slave (
        input  blk_valid, blk_data, blk_last, blk_aad, tag_ready,
        output blk_ready, tag_valid, tag
    );
endinterface
`default_nettype wire

// File: rtl/ghash_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ghash_ctrl
// Purpose  : GHASH sequencer, Y = (Y ^ X) * H over an external multiplier.
//            Optional length block enabled by macro GHASH_LEN_BLOCK_EN.
// Revision : 1.0  initial release
// ============================================================================
module ghash_ctrl #(
    parameter int MUL_LAT = 1,
    parameter int W       = 128
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         h_valid,
    input  wire logic [W-1:0] h_data,
    ghash_ctrl_if.slave       bus,
    output logic [W-1:0]      mul_a,
    output logic [W-1:0]      mul_b,
    input  wire logic [W-1:0] mul_p,
    output logic              busy
);
    localparam logic [3:0] C_LAT_LAST = 4'(MUL_LAT);

`ifdef GHASH_LEN_BLOCK_EN
    typedef enum logic [1:0] {
        S_ACCEPT = 2'd0,
        S_MUL    = 2'd1,
        S_LENMUL = 2'd2,
        S_DONE   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_ACCEPT = 2'd0,
        S_MUL    = 2'd1,
        S_DONE   = 2'd3
    } state_t;
`endif

    state_t       state_q, state_d;
    logic [W-1:0] h_q, h_d;
    logic [W-1:0] y_q, y_d;
    logic [W-1:0] mul_a_q, mul_a_d;
    logic [W-1:0] tag_q, tag_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         h_loaded_q, h_loaded_d;
    logic         last_q, last_d;
    logic         blk_ready_q, blk_ready_d;
    logic         tag_valid_q, tag_valid_d;
    logic         busy_q, busy_d;
`ifdef GHASH_LEN_BLOCK_EN
    logic [63:0]  aad_bits_q, aad_bits_d;
    logic [63:0]  ct_bits_q, ct_bits_d;
`else
    logic         w_unused_aad;
    assign w_unused_aad = bus.blk_aad;
`endif

    logic w_blk_hs, w_tag_hs, w_mul_done;
    // blk_ready_q is only ever high in ACCEPT, so it fully qualifies the handshake
    assign w_blk_hs   = bus.blk_valid & blk_ready_q;
    assign w_tag_hs   = tag_valid_q & bus.tag_ready;
    assign w_mul_done = (cnt_q == C_LAT_LAST);

    always_comb begin
        state_d    = state_q;
        h_d        = h_q;
        y_d        = y_q;
        mul_a_d    = mul_a_q;
        cnt_d      = cnt_q;
        h_loaded_d = h_loaded_q;
        last_d     = last_q;
`ifdef GHASH_LEN_BLOCK_EN
        aad_bits_d = aad_bits_q;
        ct_bits_d  = ct_bits_q;
`endif
        case (state_q)
            S_ACCEPT: begin
                if (h_valid) begin
                    h_d        = h_data;
                    h_loaded_d = 1'b1;
                end
                if (w_blk_hs) begin
                    mul_a_d = y_q ^ bus.blk_data;
                    last_d  = bus.blk_last;
                    cnt_d   = 4'd0;
                    state_d = S_MUL;
`ifdef GHASH_LEN_BLOCK_EN
                    if (bus.blk_aad) aad_bits_d = aad_bits_q + 64'd128;
                    else             ct_bits_d  = ct_bits_q + 64'd128;
`endif
                end
            end
            S_MUL: begin
                if (w_mul_done) begin
                    y_d   = mul_p;
                    cnt_d = 4'd0;
                    if (!last_q) begin
                        state_d = S_ACCEPT;
                    end else begin
`ifdef GHASH_LEN_BLOCK_EN
                        mul_a_d = mul_p ^ {aad_bits_q, ct_bits_q};
                        state_d = S_LENMUL;
`else
                        state_d = S_DONE;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
`ifdef GHASH_LEN_BLOCK_EN
            S_LENMUL: begin
                if (w_mul_done) begin
                    y_d     = mul_p;
                    cnt_d   = 4'd0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
`endif
            S_DONE: begin
                if (w_tag_hs) begin
                    y_d     = '0;
                    state_d = S_ACCEPT;
`ifdef GHASH_LEN_BLOCK_EN
                    aad_bits_d = 64'd0;
                    ct_bits_d  = 64'd0;
`endif
                end
            end
            default: state_d = S_ACCEPT;
        endcase

        // outputs are registered from the next-state view
        blk_ready_d = (state_d == S_ACCEPT) & h_loaded_d;
        tag_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_ACCEPT);
        tag_d       = (state_d == S_DONE) ? y_d : tag_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_ACCEPT;
            h_q         <= '0;
            y_q         <= '0;
            mul_a_q     <= '0;
            tag_q       <= '0;
            cnt_q       <= 4'd0;
            h_loaded_q  <= 1'b0;
            last_q      <= 1'b0;
            blk_ready_q <= 1'b0;
            tag_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef GHASH_LEN_BLOCK_EN
            aad_bits_q  <= 64'd0;
            ct_bits_q   <= 64'd0;
`endif
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            y_q         <= y_d;
            mul_a_q     <= mul_a_d;
            tag_q       <= tag_d;
            cnt_q       <= cnt_d;
            h_loaded_q  <= h_loaded_d;
            last_q      <= last_d;
            blk_ready_q <= blk_ready_d;
            tag_valid_q <= tag_valid_d;
            busy_q      <= busy_d;
`ifdef GHASH_LEN_BLOCK_EN
            aad_bits_q  <= aad_bits_d;
            ct_bits_q   <= ct_bits_d;
`endif
        end
    end

    assign mul_a         = mul_a_q;
    assign mul_b         = h_q;
    assign busy          = busy_q;
    assign bus.blk_ready = blk_ready_q;
    assign bus.tag_valid = tag_valid_q;
    assign bus.tag       = tag_q;
endmodule
`default_nettype wire

// File: doc/ghash_ctrl.md
# ghash_ctrl

Sequencing controller for the GHASH engine. It owns the hash key H and the running accumulator Y, and accepts 128-bit blocks over a valid/ready handshake. For each block it drives the shared GF(2^128) multiply-and-reduce datapath with Y = (Y ^ X) * H, and returns the final accumulator as the tag over a second handshake. The multiplier (`cmul` + `reduction` under `top`) sits outside this block and is reached through the `mul_*` ports, so it can be pipelined or shared.

## Interface
- `MUL_LAT`, 1: cycles from operands applied to `mul_p` valid. Legal range 0..15; 0 means purely combinational.
- `W`, 128: block width. Fixed at 128; exists only for port sizing.

Ports (clock and reset first):
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `h_valid` in 1: load `h_data` into the H register.
- `h_data` in 128: hash subkey H.
- `blk_valid` in 1: input block valid.
- `blk_ready` out 1: controller can accept a block.
- `blk_data` in 128: block X.
- `blk_last` in 1: X is the final block of the message.
- `blk_aad` in 1: X is AAD (1) or ciphertext (0). Used only under `GHASH_LEN_BLOCK_EN`.
- `mul_a` out 128: multiplier operand, registered.
- `mul_b` out 128: multiplier operand; always equals H.
- `mul_p` in 128: reduced product from the datapath.
- `tag_valid` out 1: tag available.
- `tag_ready` in 1: tag consumer ready.
- `tag` out 128: final accumulator value.
- `busy` out 1: high in MUL, LENMUL and DONE.

## Operation
- Reset values: `blk_ready`, `tag_valid`, `busy` = 0; `tag`, `mul_a`, `mul_b`, H, Y = 0; `h_loaded` = 0; bit counters = 0; state = ACCEPT.
- H load: `h_valid` is honoured only in ACCEPT. It sets `h_loaded` = 1. In all other states it is ignored.
- ACCEPT:
  - `blk_ready` = `h_loaded`.
  - On handshake, register `mul_a` = Y ^ `blk_data`, latch `blk_last`, and go to MUL.
  - Under the macro, also add 128 to `aad_bits` or `ct_bits` according to `blk_aad`.
- MUL:
  - Hold `mul_a` and `mul_b` for `MUL_LAT`+1 cycles, counted by a 4-bit counter.
  - On the last cycle, capture Y = `mul_p`.
  - If the latched last flag is 0, go to ACCEPT.
  - If the latched last flag is 1: without the macro, go to DONE; with the macro, set `mul_a` = `mul_p` ^ {`aad_bits`, `ct_bits`} and go to LENMUL.
- LENMUL (macro only): same wait as MUL, capture Y = `mul_p`, then go to DONE.
- DONE:
  - `tag_valid` = 1 and `tag` = Y; both held stable until `tag_ready`.
  - On handshake: Y = 0, counters = 0, go to ACCEPT.
  - H and `h_loaded` are retained across messages.
- `tag` holds its last value outside DONE; only `tag_valid` qualifies it.
- Simultaneous `h_valid` and a block handshake in ACCEPT: H updates in the same edge. The block's multiply uses the new H, because `mul_b` is driven from the H register.
- Bit counters are 64 bits and wrap modulo 2^64.
- `blk_ready` = 0 in MUL, LENMUL and DONE: no block is accepted while a tag is pending.
- Asynchronous reset at any point (including mid-MUL) aborts the operation, restores every reset value and clears `h_loaded`.

## Timing
- Block handshake at edge N.
- State MUL from cycle N+1, with `mul_a` valid.
- Y is captured at the end of cycle N+1+`MUL_LAT`.
- Non-last block: `blk_ready` returns to 1 at N+2+`MUL_LAT`. Throughput is one block per `MUL_LAT`+2 cycles.
- Last block without the macro: `tag_valid` rises at N+2+`MUL_LAT`.
- Last block with the macro: `tag_valid` rises at N+3+2·`MUL_LAT`.
- The tag handshake edge returns to ACCEPT. `blk_ready` is high the following cycle.

## Configuration
- `GHASH_LEN_BLOCK_EN` defined:
  - Per-message AAD and ciphertext bit counters are built in.
  - LENMUL is appended after the last block to fold in {`aad_bits`[63:0], `ct_bits`[63:0]}.
- `GHASH_LEN_BLOCK_EN` undefined:
  - No counters and no LENMUL state; `blk_aad` is ignored.
  - The tag is the accumulator after the last block.

## Test plan
- Reset check:
  - Assert `rst_n` = 0 -> all outputs 0.
  - Drive `blk_valid` = 1 with no H loaded -> `blk_ready` stays 0 for 20 cycles.
- Single block, stub multiplier `mul_p` = `mul_a` ^ `mul_b`, `MUL_LAT` = 1, macro off:
  - Stimulus: H = 0x…01, X = 0x…0F with `blk_last`, handshake at cycle 10.
  - Response: `mul_a` = 0x…0F from cycle 11; `tag_valid` at cycle 13; `tag` = 0x…0E.
- Real multiplier, H = 0, two blocks 0x1234…7788 and 0x0F0E…0100 -> `tag` = 0.
  - Same blocks with H reloaded in between -> `mul_b` switches on the load edge.
- Backpressure: hold `tag_ready` = 0 for 5 cycles in DONE -> `tag` and `tag_valid` stable, `blk_ready` = 0; accept on release.
- Macro on, stub multiplier, H = 0:
  - Stimulus: 1 AAD block + 2 CT blocks.
  - Response: LENMUL `mul_a` = 0x0000_0000_0000_0080_0000_0000_0000_0100; `tag` = that value.
- Reset mid-MUL: drop `rst_n` at cycle N+1 -> immediate reset values, `h_loaded` = 0.
  - After reload, the next message's tag matches a clean run.
